// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter sharing one external 8-bit ALU.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   reqN_valid/ready               per-port operation handshake (ready = grant, combinational)
//   reqN_a, reqN_b, reqN_op        per-port operands and 3-bit opcode
//   rspN_valid/ready               per-port one-entry response handshake
//   rspN_data, rspN_zero, rspN_carry  registered result and flags for port N
//   alu_a, alu_b, alu_op           operands/opcode driven to the ALU (combinational mux)
//   alu_out, alu_zero, alu_carry   combinational ALU result and flags
//   op_count                       16-bit wrapping count of completed grants
module alu_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_op,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_data,
    output logic       rsp0_zero,
    output logic       rsp0_carry,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_data,
    output logic       rsp1_zero,
    output logic       rsp1_carry,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_out,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic [15:0] op_count
);

    localparam int unsigned DATA_W = 8;

    logic last_grant;
    logic elig0, elig1;
    logic gnt0, gnt1;
    logic carry_valid;
    logic res_zero;

    // Zero flag is recomputed from the result; the ALU's own flag is not used.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    // A slot is free when empty or being drained this cycle; reset blocks all grants.
    always_comb begin
        elig0 = rst_n && req0_valid && (!rsp0_valid || rsp0_ready);
        elig1 = rst_n && req1_valid && (!rsp1_valid || rsp1_ready);
        gnt0  = elig0 && (!elig1 || last_grant);
        gnt1  = elig1 && !gnt0;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // ALU operand mux: port 0 by default when idle.
    always_comb begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_op = req0_op;
        if (gnt1) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end
    end

    // Carry is only meaningful for add/sub.
    assign carry_valid = (alu_op[2:1] == 2'b00);
    assign res_zero    = (alu_out == DATA_W'(0));

    // Response slots, round-robin pointer and grant counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_zero  <= 1'b0;
            rsp0_carry <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_zero  <= 1'b0;
            rsp1_carry <= 1'b0;
            last_grant <= 1'b1;
            op_count   <= '0;
        end else begin
            if (gnt0) begin
                rsp0_valid <= 1'b1;
                rsp0_data  <= alu_out;
                rsp0_zero  <= res_zero;
                rsp0_carry <= carry_valid && alu_carry;
            end else if (rsp0_valid && rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end

            if (gnt1) begin
                rsp1_valid <= 1'b1;
                rsp1_data  <= alu_out;
                rsp1_zero  <= res_zero;
                rsp1_carry <= carry_valid && alu_carry;
            end else if (rsp1_valid && rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end

            if (gnt0 || gnt1) begin
                last_grant <= gnt1;
                op_count   <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and per-port scoreboards.
module tb_alu_arbiter;

    logic       clk, rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       rsp0_valid, rsp0_ready, rsp0_zero, rsp0_carry;
    logic       rsp1_valid, rsp1_ready, rsp1_zero, rsp1_carry;
    logic [7:0] rsp0_data, rsp1_data;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_op;
    logic       alu_zero, alu_carry;
    logic [15:0] op_count;

    int errors = 0;
    int checks = 0;

    // Bench model state
    logic        m_last;
    logic        m_v0, m_v1;
    logic [15:0] m_cnt;
    logic [9:0]  q0[$];
    logic [9:0]  q1[$];
    logic        obs_g1;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero), .rsp0_carry(rsp0_carry),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero), .rsp1_carry(rsp1_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] alu_raw(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0:    alu_raw = {1'b0, a} + {1'b0, b};
            3'd1:    alu_raw = {1'b0, a} - {1'b0, b};
            3'd2:    alu_raw = {1'b0, a & b};
            3'd3:    alu_raw = {1'b0, a | b};
            3'd4:    alu_raw = {1'b0, a ^ b};
            3'd5:    alu_raw = {1'b0, ~a};
            3'd6:    alu_raw = {1'b0, a[6:0], 1'b0};
            default: alu_raw = {2'b00, a[7:1]};
        endcase
    endfunction

    // External ALU: carry output is deliberately 1 (garbage) for logic ops.
    always_comb begin
        logic [8:0] s;
        s         = alu_raw(alu_a, alu_b, alu_op);
        alu_out   = s[7:0];
        alu_zero  = (s[7:0] == 8'd0);
        alu_carry = (alu_op < 3'd2) ? s[8] : 1'b1;
    end

    // Expected {data, zero, carry}
    function automatic logic [9:0] calc(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
        logic [8:0] s;
        s = alu_raw(a, b, op);
        calc = {s[7:0], (s[7:0] == 8'd0), (op < 3'd2) ? s[8] : 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    endtask

    task automatic set1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    endtask

    task automatic model_reset();
        m_last = 1'b1; m_v0 = 1'b0; m_v1 = 1'b0; m_cnt = 16'd0;
        q0.delete(); q1.delete();
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_rsp0_valid"}, 32'(rsp0_valid), 32'd0);
        chk({tag, "_rsp1_valid"}, 32'(rsp1_valid), 32'd0);
        chk({tag, "_rsp0_flags"}, {22'd0, rsp0_data, rsp0_zero, rsp0_carry}, 32'd0);
        chk({tag, "_rsp1_flags"}, {22'd0, rsp1_data, rsp1_zero, rsp1_carry}, 32'd0);
        chk({tag, "_op_count"}, 32'(op_count), 32'd0);
        chk({tag, "_ready"}, {30'd0, req0_ready, req1_ready}, 32'd0);
    endtask

    // Reset with requests pending, release at a negedge, return just after a posedge.
    task automatic do_reset();
        set0(1'b1, 8'h11, 8'h22, 3'd0);
        set1(1'b1, 8'h33, 8'h44, 3'd0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;
        set0(1'b0, 8'h00, 8'h00, 3'd0);
        set1(1'b0, 8'h00, 8'h00, 3'd0);
        @(posedge clk); #1;
    endtask

    // One clock: compare against the model mid-cycle, update the model, advance.
    task automatic step();
        logic e0, e1, g0, g1;
        @(negedge clk);
        e0 = req0_valid && (!m_v0 || rsp0_ready);
        e1 = req1_valid && (!m_v1 || rsp1_ready);
        g0 = e0 && (!e1 || m_last);
        g1 = e1 && !g0;
        obs_g1 = req1_ready;
        chk("req0_ready", 32'(req0_ready), 32'(g0));
        chk("req1_ready", 32'(req1_ready), 32'(g1));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(m_v0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(m_v1));
        chk("op_count", 32'(op_count), 32'(m_cnt));
        if (m_v0 && q0.size() > 0)
            chk("rsp0_payload", {22'd0, rsp0_data, rsp0_zero, rsp0_carry}, 32'(q0[0]));
        if (m_v1 && q1.size() > 0)
            chk("rsp1_payload", {22'd0, rsp1_data, rsp1_zero, rsp1_carry}, 32'(q1[0]));
        if (g0)
            chk("alu_drive0", {13'd0, alu_a, alu_b, alu_op}, {13'd0, req0_a, req0_b, req0_op});
        if (g1)
            chk("alu_drive1", {13'd0, alu_a, alu_b, alu_op}, {13'd0, req1_a, req1_b, req1_op});
        if (m_v0 && rsp0_ready) begin void'(q0.pop_front()); m_v0 = 1'b0; end
        if (m_v1 && rsp1_ready) begin void'(q1.pop_front()); m_v1 = 1'b0; end
        if (g0) begin q0.push_back(calc(req0_a, req0_b, req0_op)); m_v0 = 1'b1; end
        if (g1) begin q1.push_back(calc(req1_a, req1_b, req1_op)); m_v1 = 1'b1; end
        if (g0 || g1) begin m_last = g1; m_cnt = m_cnt + 16'd1; end
        @(posedge clk); #1;
    endtask

    logic [7:0] held;

    initial begin
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set0(1'b0, 8'h00, 8'h00, 3'd0);
        set1(1'b0, 8'h00, 8'h00, 3'd0);
        obs_g1 = 1'b0;
        do_reset();

        // 1: single add with carry
        set0(1'b1, 8'hF0, 8'h20, 3'd0);
        step();
        set0(1'b0, 8'h00, 8'h00, 3'd0);
        chk("t1_valid", 32'(rsp0_valid), 32'd1);
        chk("t1_data", 32'(rsp0_data), 32'h10);
        chk("t1_carry_zero", {30'd0, rsp0_carry, rsp0_zero}, 32'b10);
        chk("t1_count", 32'(op_count), 32'd1);
        step();

        // 2: sub with borrow, then sub to zero
        set1(1'b1, 8'h05, 8'h06, 3'd1);
        step();
        chk("t2a_data", 32'(rsp1_data), 32'hFF);
        chk("t2a_carry_zero", {30'd0, rsp1_carry, rsp1_zero}, 32'b10);
        set1(1'b1, 8'h33, 8'h33, 3'd1);
        step();
        set1(1'b0, 8'h00, 8'h00, 3'd0);
        chk("t2b_data", 32'(rsp1_data), 32'h00);
        chk("t2b_carry_zero", {30'd0, rsp1_carry, rsp1_zero}, 32'b01);
        step();

        // 3: round-robin after reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set0(1'b1, 8'(i), 8'h10, 3'(i));
            set1(1'b1, 8'(i + 8'h40), 8'h03, 3'(i + 4));
            step();
            chk("rr_grant", 32'(obs_g1), 32'(i % 2));
        end
        chk("rr_count", 32'(op_count), 32'd4);

        // 4: backpressure on port 0
        rsp0_ready = 1'b0;
        set0(1'b1, 8'h55, 8'h0F, 3'd2);
        set1(1'b1, 8'h0A, 8'h01, 3'd0);
        step();
        held = rsp0_data;
        for (int i = 0; i < 3; i++) begin
            set1(1'b1, 8'(8'h20 + i), 8'h01, 3'd1);
            step();
            chk("bp_hold", 32'(rsp0_data), 32'(held));
        end
        rsp0_ready = 1'b1;
        step();
        chk("bp_refill_valid", 32'(rsp0_valid), 32'd1);
        chk("bp_refill_data", 32'(rsp0_data), 32'h05);
        set0(1'b0, 8'h00, 8'h00, 3'd0);
        set1(1'b0, 8'h00, 8'h00, 3'd0);
        step();

        // 5: logic ops clear carry
        set0(1'b1, 8'hFF, 8'h01, 3'd0);
        step();
        chk("t5_add_carry", 32'(rsp0_carry), 32'd1);
        set0(1'b1, 8'h81, 8'h00, 3'd6);
        step();
        chk("t5_shl", {22'd0, rsp0_data, rsp0_zero, rsp0_carry}, {22'd0, 8'h02, 2'b00});
        set0(1'b1, 8'hFF, 8'h00, 3'd5);
        step();
        chk("t5_not", {22'd0, rsp0_data, rsp0_zero, rsp0_carry}, {22'd0, 8'h00, 2'b10});
        set0(1'b0, 8'h00, 8'h00, 3'd0);
        for (int op = 0; op < 8; op++) begin
            set1(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'(op));
            step();
        end
        set1(1'b0, 8'h00, 8'h00, 3'd0);
        step();

        // 6: counter wrap, then asynchronous reset with a held response
        do_reset();
        set1(1'b1, 8'h12, 8'h34, 3'd0);
        for (int i = 0; i < 65536; i++) step();
        chk("wrap_count", 32'(op_count), 32'd0);
        rsp1_ready = 1'b0;
        set1(1'b1, 8'h01, 8'h02, 3'd0);
        step();
        set1(1'b0, 8'h00, 8'h00, 3'd0);
        chk("pre_async_valid", 32'(rsp1_valid), 32'd1);
        set1(1'b1, 8'h07, 8'h07, 3'd4);
        rst_n = 1'b0;
        #1;
        chk_cleared("async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set1(1'b0, 8'h00, 8'h00, 3'd0);
        rsp1_ready = 1'b1;
        @(posedge clk); #1;
        step();
        chk("post_reset_empty", 32'(rsp1_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
